ila_capture_core: RTL and testbench

//  Parametrised in-fabric debug capture core. Successor to per-site vendor ILA instantiation.

---
 rtl/ila_capture_core.sv | 129 ++++++++++++
 tb/tb_ila_capture_core.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ila_capture_core.sv
// In-fabric debug capture core: probe sampling, masked level/edge trigger with run-time
// pre-trigger depth, circular capture RAM and random-access logical readout.
module ila_capture_core #(
    parameter int unsigned NUM_PROBES = 6,
    parameter int unsigned PROBE_W    = 16,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned DW        = NUM_PROBES * PROBE_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] probe_in,
    input  logic          arm,
    input  logic [DW-1:0] trig_mask,
    input  logic [DW-1:0] trig_value,
    input  logic          trig_edge,
    input  logic [AW-1:0] pretrig_cnt,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [2:0]    state_o,
    output logic          done,
    output logic [AW-1:0] trig_pos
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] samp;
    logic          match_prev, edge_l;
    logic [AW-1:0] wr_ptr, cnt, post, start, pre_l, pre_in;
    logic          match, hit, arm_go, wr_en, trig_go;

    // Pre-trigger depth saturates at DEPTH-1 so at least the trigger sample fits.
    always_comb begin
        if (32'(pretrig_cnt) > DEPTH - 1) pre_in = AW'(DEPTH - 1);
        else                              pre_in = pretrig_cnt;
    end

    assign match   = ((samp ^ trig_value) & trig_mask) == '0;
    assign hit     = edge_l ? (match & ~match_prev) : match;
    assign state_o = state;

    always_comb begin
        state_n = state;
        arm_go  = 1'b0;
        wr_en   = 1'b0;
        trig_go = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    arm_go  = 1'b1;
                    state_n = (pre_in == '0) ? ST_WAIT : ST_PRE;
                end
            end
            ST_PRE: begin
                wr_en = 1'b1;
                if (cnt == pre_l - AW'(1)) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                wr_en = 1'b1;
                if (hit) begin
                    trig_go = 1'b1;
                    state_n = (pre_l == AW'(DEPTH - 1)) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                wr_en = 1'b1;
                if (post == AW'(1)) state_n = ST_DONE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            done       <= 1'b0;
            samp       <= '0;
            match_prev <= 1'b0;
            edge_l     <= 1'b0;
            wr_ptr     <= '0;
            cnt        <= '0;
            post       <= '0;
            start      <= '0;
            pre_l      <= '0;
            trig_pos   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            done       <= (state_n == ST_DONE);
            samp       <= probe_in;
            match_prev <= arm_go ? 1'b0 : match;
            if (arm_go) begin
                pre_l    <= pre_in;
                edge_l   <= trig_edge;
                trig_pos <= pre_in;
                wr_ptr   <= '0;
                cnt      <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (state == ST_PRE)  cnt  <= cnt + AW'(1);
                if (state == ST_POST) post <= post - AW'(1);
                // Oldest kept sample sits pre_l slots behind the trigger slot.
                if (trig_go) begin
                    start <= wr_ptr - pre_l;
                    post  <= AW'(DEPTH - 1) - pre_l;
                end
            end
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[start + rd_addr];
        end
    end

    // Capture RAM is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= samp;
    end

endmodule

// File: tb/tb_ila_capture_core.sv
// Directed self-checking bench for ila_capture_core (DEPTH=16): ch0 carries a sample
// counter, ch1 a controllable level, expected buffers are hand-derived.
module tb_ila_capture_core;

    localparam int unsigned NP = 6;
    localparam int unsigned PW = 16;
    localparam int unsigned DP = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = NP * PW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] probe_in;
    logic          arm;
    logic [DW-1:0] trig_mask;
    logic [DW-1:0] trig_value;
    logic          trig_edge;
    logic [AW-1:0] pretrig_cnt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    state_o;
    logic          done;
    logic [AW-1:0] trig_pos;

    logic [15:0] ctr;
    logic [15:0] ch1;
    int          checks = 0;
    int          failures = 0;

    ila_capture_core #(.NUM_PROBES(NP), .PROBE_W(PW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .probe_in(probe_in), .arm(arm),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_edge(trig_edge),
        .pretrig_cnt(pretrig_cnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .state_o(state_o),
        .done(done), .trig_pos(trig_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] w(input logic [15:0] c1, input logic [15:0] c0);
        return {64'h0, c1, c0};
    endfunction

    task automatic drive();
        probe_in = w(ch1, ctr);
    endtask

    // One clock: pulses clear, counter advances on the probe bus.
    task automatic tick();
        @(posedge clk);
        #1;
        arm = 1'b0;
        rst = 1'b0;
        ctr = ctr + 16'd1;
        drive();
    endtask

    task automatic start(input logic [AW-1:0] pre, input logic edg,
                         input logic [DW-1:0] mask, input logic [DW-1:0] val);
        pretrig_cnt = pre;
        trig_edge   = edg;
        trig_mask   = mask;
        trig_value  = val;
        ctr         = 16'd0;
        drive();
        arm = 1'b1;
        tick();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state_o !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 128'(state_o), 128'(st));
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check(tag, 128'({rd_valid, rd_data}), 128'({1'b1, exp}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; rd_en = 1'b0; rd_addr = '0;
        trig_mask = '0; trig_value = '0; trig_edge = 1'b0; pretrig_cnt = '0;
        ctr = 16'd0; ch1 = 16'd0;
        drive();
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        check("rst_state", 128'(state_o), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_rd", 128'({rd_valid, rd_data}), 128'(0));
        check("rst_trig_pos", 128'(trig_pos), 128'(0));

        // T1: level trigger on ch0==7 with 4 pre-trigger samples
        start(4'd4, 1'b0, {DW{1'b1}}, w(16'h0, 16'h7));
        wait_state("t1_done_state", 3'd4, 100);
        check("t1_done", 128'(done), 128'(1));
        check("t1_done_time", 128'(ctr), 128'(20));
        check("t1_trig_pos", 128'(trig_pos), 128'(4));
        for (int i = 0; i < 16; i++) rd_check("t1_rd", AW'(i), w(16'h0, 16'(i + 3)));
        tick();
        check("t1_rd_valid_idle", 128'(rd_valid), 128'(0));

        // T2: no pre-trigger, all-zero mask triggers on the first WAIT sample
        start(4'd0, 1'b0, '0, '0);
        wait_state("t2_done_state", 3'd4, 100);
        check("t2_done_time", 128'(ctr), 128'(17));
        check("t2_trig_pos", 128'(trig_pos), 128'(0));
        rd_check("t2_rd0", 4'd0, w(16'h0, 16'd0));
        rd_check("t2_rd1", 4'd1, w(16'h0, 16'd1));
        rd_check("t2_rd15", 4'd15, w(16'h0, 16'd15));

        // T3: edge mode, ch1 matches before arm, drops at 30, rises at 40
        ch1 = 16'h00FF;
        start(4'd2, 1'b1, {DW{1'b0}} | (DW'(16'hFFFF) << 16), w(16'h00FF, 16'h0));
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            if (ctr == 16'd30) ch1 = 16'h0000;
            if (ctr == 16'd40) ch1 = 16'h00FF;
            drive();
        end
        check("t3_done", 128'(done), 128'(1));
        check("t3_done_time", 128'(ctr), 128'(55));
        check("t3_trig_pos", 128'(trig_pos), 128'(2));
        rd_check("t3_rd0", 4'd0, w(16'h0000, 16'd38));
        rd_check("t3_rd1", 4'd1, w(16'h0000, 16'd39));
        rd_check("t3_rd2", 4'd2, w(16'h00FF, 16'd40));
        rd_check("t3_rd15", 4'd15, w(16'h00FF, 16'd53));

        // T4: maximum pre-trigger depth, DONE directly on the trigger write
        ch1 = 16'h0;
        start(4'd15, 1'b0, DW'(16'hFFFF), w(16'h0, 16'd30));
        wait_state("t4_done_state", 3'd4, 100);
        check("t4_done_time", 128'(ctr), 128'(32));
        check("t4_trig_pos", 128'(trig_pos), 128'(15));
        rd_check("t4_rd0", 4'd0, w(16'h0, 16'd15));
        rd_check("t4_rd15", 4'd15, w(16'h0, 16'd30));

        // T5: arm ignored in WAIT, reset in POST squashes read, then re-arm
        start(4'd4, 1'b0, DW'(16'hFFFF), w(16'h0, 16'd50));
        wait_state("t5_wait", 3'd2, 20);
        pretrig_cnt = 4'd9;
        arm = 1'b1;
        tick();
        check("t5_arm_ignored", 128'(state_o), 128'(2));
        check("t5_trig_pos_kept", 128'(trig_pos), 128'(4));
        wait_state("t5_post", 3'd3, 100);
        rst = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        check("t5_rst_state", 128'(state_o), 128'(0));
        check("t5_rst_done", 128'(done), 128'(0));
        check("t5_rst_rd_valid", 128'(rd_valid), 128'(0));
        start(4'd4, 1'b0, DW'(16'hFFFF), w(16'h0, 16'd50));
        wait_state("t5_done_state", 3'd4, 100);
        check("t5_done_time", 128'(ctr), 128'(63));
        rd_check("t5_rd0", 4'd0, w(16'h0, 16'd46));
        rd_check("t5_rd4", 4'd4, w(16'h0, 16'd50));
        rd_check("t5_rd15", 4'd15, w(16'h0, 16'd61));

        // T6: long WAIT wraps the write pointer several times
        start(4'd3, 1'b0, DW'(16'hFFFF), w(16'h0, 16'd60));
        wait_state("t6_done_state", 3'd4, 200);
        check("t6_done_time", 128'(ctr), 128'(74));
        for (int i = 0; i < 16; i++) rd_check("t6_rd", AW'(i), w(16'h0, 16'(i + 57)));

        // Arm together with a read in DONE: read sees the old buffer
        pretrig_cnt = 4'd3;
        arm = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        check("t6_rbw_rd", 128'({rd_valid, rd_data}), 128'({1'b1, w(16'h0, 16'd57)}));
        check("t6_rearm_done", 128'(done), 128'(0));
        check("t6_rearm_state", 128'(state_o), 128'(1));
        tick();
        check("t6_rd_valid_idle", 128'(rd_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
